// File: rtl/div32_if.sv
// Handshake and operand/result bundle between a requester and div32_seq.
interface div32_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_op, x, y,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, x, y,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div32_seq.sv
// Sequential restoring divider, one compare-and-subtract step per clock.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands, magnitudes and sign flags load
// RUN   | WIDTH shift/trial-subtract iterations, counter counts down
// FIX   | sign correction or divide-by-zero result into output regs
// DONE  | one wait cycle; done pulses on the edge leaving this state
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  rst,
   div32_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] rem, quo, ymag;
   logic [CW-1:0]    cnt;
   logic             xneg, yneg, dz;
   logic [WIDTH-1:0] xmag_in, ymag_in;
   logic [WIDTH+1:0] trial;

   // Operand magnitudes and the trial subtract; trial MSB is the borrow-out.
   always_comb begin
      xmag_in = (bus.signed_op & bus.x[WIDTH-1]) ? -bus.x : bus.x;
      ymag_in = (bus.signed_op & bus.y[WIDTH-1]) ? -bus.y : bus.y;
      trial   = {1'b0, rem, quo[WIDTH-1]} - {2'b00, ymag};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state decode; start is only looked at in IDLE.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (bus.start) state_n = (bus.y == '0) ? FIX : RUN;
         RUN:  if (cnt == CW'(1)) state_n = FIX;
         FIX:  state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem             <= '0;
         quo             <= '0;
         ymag            <= '0;
         cnt             <= '0;
         xneg            <= 1'b0;
         yneg            <= 1'b0;
         dz              <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               xneg     <= bus.signed_op & bus.x[WIDTH-1];
               yneg     <= bus.signed_op & bus.y[WIDTH-1];
               ymag     <= ymag_in;
               cnt      <= CW'(WIDTH);
               bus.busy <= 1'b1;
               if (bus.y == '0) begin
                  // Raw dividend parks in rem so FIX can return it unchanged.
                  dz  <= 1'b1;
                  rem <= bus.x;
                  quo <= '0;
               end else begin
                  dz  <= 1'b0;
                  rem <= '0;
                  quo <= xmag_in;
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (!trial[WIDTH+1]) begin
                  rem <= trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               bus.busy <= 1'b0;
               if (dz) begin
                  bus.quotient    <= '1;
                  bus.remainder   <= rem;
                  bus.div_by_zero <= 1'b1;
               end else begin
                  bus.quotient    <= (xneg ^ yneg) ? -quo : quo;
                  bus.remainder   <= xneg ? -rem : rem;
                  bus.div_by_zero <= 1'b0;
               end
            end
            DONE: bus.done <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: vector table through a scoreboard plus control sequences.
module tb_div32_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   div32_if #(.WIDTH(32)) bus ();

   div32_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      logic signed [31:0] sa, sbv;
      v.s = s; v.x = a; v.y = b; v.dz = 1'b0; v.lat = 34;
      sa = a; sbv = b;
      if (b == 0) begin
         v.q = '1; v.r = a; v.dz = 1'b1; v.lat = 2;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         v.q = a; v.r = 0;
      end else if (s) begin
         v.q = sa / sbv; v.r = sa % sbv;
      end else begin
         v.q = a / b; v.r = a % b;
      end
      return v;
   endfunction

   task automatic drive(input vec_t v);
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = v.s; bus.x = v.x; bus.y = v.y;
      sb.push_back(v);
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int   nbusy, lat;
      logic got, overlap;
      vec_t e;
      drive(v);
      @(posedge clk); #1;
      bus.start = 1'b0;
      nbusy = int'(bus.busy); got = 1'b0; overlap = 1'b0; lat = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (bus.busy && bus.done) overlap = 1'b1;
         if (bus.done) begin got = 1'b1; lat = n; break; end
         nbusy += int'(bus.busy);
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s timeout got=no_done expected=done", tag);
         sb.delete();
         return;
      end
      e = sb.pop_front();
      chk({tag, " quotient"}, bus.quotient, e.q);
      chk({tag, " remainder"}, bus.remainder, e.r);
      chk({tag, " dz"}, 32'(bus.div_by_zero), 32'(e.dz));
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " busy_cycles"}, 32'(nbusy), 32'(e.lat - 1));
      chk({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int   ndone;
      vec_t e;
      bus.start = 1'b0; bus.signed_op = 1'b0; bus.x = '0; bus.y = '0;

      vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34});
      vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34});
      vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34});
      vecs.push_back('{1'b0, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,          1'b0, 34});
      vecs.push_back('{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 2});
      vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34});
      vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34});
      vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 2});
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom >> $urandom_range(0, 28);
         if (b == 0) b = 32'd3;
         vecs.push_back(model(i[0], a, b));
      end

      // reset state
      @(posedge clk); #1;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset quotient", bus.quotient, 32'd0);
      chk("reset remainder", bus.remainder, 32'd0);
      chk("reset dz", 32'(bus.div_by_zero), 32'd0);
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // second start during RUN is dropped
      drive('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34});
      @(posedge clk); #1; bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
      @(negedge clk); bus.start = 1'b0;
      ndone = 0;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            ndone++;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("ignore quotient", bus.quotient, e.q);
               chk("ignore remainder", bus.remainder, e.r);
            end
         end
      end
      chk("ignore done_count", 32'(ndone), 32'd1);

      // asynchronous reset in the middle of RUN
      drive('{1'b0, 32'hDEAD_BEEF, 32'd5, 32'd0, 32'd0, 1'b0, 34});
      @(posedge clk); #1; bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst quotient", bus.quotient, 32'd0);
      chk("rst remainder", bus.remainder, 32'd0);
      chk("rst dz", 32'(bus.div_by_zero), 32'd0);
      sb.delete();
      @(negedge clk); rst = 1'b0;
      run_op('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34}, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
